// File: rtl/pixel_serializer.sv
// pixel_serializer: parallel-to-serial pixel shifter for the video output path.
// Words enter a one-deep holding buffer through valid/ready, then are shifted
// out on pixel ticks during active video, each bit repeated scale+1 times.
//
// state | meaning
// IDLE  | no word in the shifter; the next active tick needs a new word
// SHIFT | a word is being driven out, bit index idx_q, repeat count rep_q
module pixel_serializer #(
  parameter int WIDTH   = 8,
  parameter int SCALE_W = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               display_area_enable,
  input  logic [WIDTH-1:0]   parallel_in,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               lsb_first,
  input  logic [SCALE_W-1:0] scale,
  output logic               serial_out,
  output logic               serial_valid,
  output logic               word_start,
  output logic               underrun
);

  localparam int               IDX_W    = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_d;
  logic               ready_en_q, ready_en_d;
  logic               hold_full_q, hold_full_d;
  logic [WIDTH-1:0]   hold_word_q, hold_word_d;
  logic               hold_lsb_q, hold_lsb_d;
  logic [SCALE_W-1:0] hold_scale_q, hold_scale_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic               lsb_q, lsb_d;
  logic [SCALE_W-1:0] scale_q, scale_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SCALE_W-1:0] rep_q, rep_d;
  logic               serial_out_q, serial_out_d;
  logic               serial_valid_q, serial_valid_d;
  logic               word_start_q, word_start_d;
  logic               underrun_q, underrun_d;

  logic               accept;
  logic               need_word;
  logic [IDX_W-1:0]   idx_next;
  logic [IDX_W-1:0]   sel;

  // ready_en_q keeps in_ready low during reset and for the release edge
  assign in_ready     = ready_en_q && !hold_full_q;
  assign serial_out   = serial_out_q;
  assign serial_valid = serial_valid_q;
  assign word_start   = word_start_q;
  assign underrun     = underrun_q;

  // Next-state: buffer handshake every clk, shifter only on pixel ticks
  always_comb begin
    accept    = in_valid && in_ready;
    need_word = (state_q == IDLE) || ((idx_q == LAST_IDX) && (rep_q == scale_q));
    idx_next  = idx_q + IDX_W'(1);
    sel       = lsb_q ? idx_next : (LAST_IDX - idx_next);

    state_d        = state_q;
    ready_en_d     = 1'b1;
    hold_full_d    = hold_full_q;
    hold_word_d    = hold_word_q;
    hold_lsb_d     = hold_lsb_q;
    hold_scale_d   = hold_scale_q;
    word_d         = word_q;
    lsb_d          = lsb_q;
    scale_d        = scale_q;
    idx_d          = idx_q;
    rep_d          = rep_q;
    serial_out_d   = serial_out_q;
    serial_valid_d = serial_valid_q;
    word_start_d   = 1'b0;
    underrun_d     = underrun_q;

    if (accept) begin
      hold_full_d  = 1'b1;
      hold_word_d  = parallel_in;
      hold_lsb_d   = lsb_first;
      hold_scale_d = scale;
    end

    if (enable) begin
      if (!display_area_enable) begin
        // blanking drops any partial word but keeps the buffered one
        state_d        = IDLE;
        idx_d          = '0;
        rep_d          = '0;
        serial_out_d   = 1'b0;
        serial_valid_d = 1'b0;
      end else if (need_word) begin
        idx_d = '0;
        rep_d = '0;
        if (hold_full_q) begin
          state_d        = SHIFT;
          hold_full_d    = 1'b0;
          word_d         = hold_word_q;
          lsb_d          = hold_lsb_q;
          scale_d        = hold_scale_q;
          serial_out_d   = hold_lsb_q ? hold_word_q[0] : hold_word_q[WIDTH-1];
          serial_valid_d = 1'b1;
          word_start_d   = 1'b1;
        end else begin
          state_d        = IDLE;
          serial_out_d   = 1'b0;
          serial_valid_d = 1'b0;
          underrun_d     = 1'b1;
        end
      end else if (rep_q != scale_q) begin
        rep_d = rep_q + SCALE_W'(1);
      end else begin
        rep_d        = '0;
        idx_d        = idx_next;
        serial_out_d = word_q[sel];
      end
    end
  end

  // Register update with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      ready_en_q     <= 1'b0;
      hold_full_q    <= 1'b0;
      hold_word_q    <= '0;
      hold_lsb_q     <= 1'b0;
      hold_scale_q   <= '0;
      word_q         <= '0;
      lsb_q          <= 1'b0;
      scale_q        <= '0;
      idx_q          <= '0;
      rep_q          <= '0;
      serial_out_q   <= 1'b0;
      serial_valid_q <= 1'b0;
      word_start_q   <= 1'b0;
      underrun_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ready_en_q     <= ready_en_d;
      hold_full_q    <= hold_full_d;
      hold_word_q    <= hold_word_d;
      hold_lsb_q     <= hold_lsb_d;
      hold_scale_q   <= hold_scale_d;
      word_q         <= word_d;
      lsb_q          <= lsb_d;
      scale_q        <= scale_d;
      idx_q          <= idx_d;
      rep_q          <= rep_d;
      serial_out_q   <= serial_out_d;
      serial_valid_q <= serial_valid_d;
      word_start_q   <= word_start_d;
      underrun_q     <= underrun_d;
    end
  end

endmodule

// File: tb/tb_pixel_serializer.sv
// Testbench for pixel_serializer: directed scenarios plus a randomized run
// checked against a pixel-queue reference model.
module tb_pixel_serializer;

  localparam int WIDTH   = 8;
  localparam int SCALE_W = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               enable = 1'b0;
  logic               display_area_enable = 1'b0;
  logic [WIDTH-1:0]   parallel_in = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               lsb_first = 1'b0;
  logic [SCALE_W-1:0] scale = '0;
  logic               serial_out;
  logic               serial_valid;
  logic               word_start;
  logic               underrun;

  pixel_serializer #(.WIDTH(WIDTH), .SCALE_W(SCALE_W)) dut (
    .clk                 (clk),
    .reset               (reset),
    .enable              (enable),
    .display_area_enable (display_area_enable),
    .parallel_in         (parallel_in),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .lsb_first           (lsb_first),
    .scale               (scale),
    .serial_out          (serial_out),
    .serial_valid        (serial_valid),
    .word_start          (word_start),
    .underrun            (underrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0]   w;
    logic               lsb;
    logic [SCALE_W-1:0] sc;
  } word_t;

  word_t tx_q[$];
  logic  feed_gate = 1'b1;
  int    n_tests = 0;
  int    n_fail  = 0;

  // Reference model: the current word is a queue of output pixels
  bit                 m_q[$];
  logic               m_ready_en = 1'b0;
  logic               m_hold_full = 1'b0;
  word_t              m_hold;
  logic               m_out = 1'b0, m_valid = 1'b0, m_ws = 1'b0, m_under = 1'b0;

  task automatic model_update();
    logic acc;
    if (reset) begin
      m_q.delete();
      m_ready_en  = 1'b0;
      m_hold_full = 1'b0;
      m_out = 1'b0; m_valid = 1'b0; m_ws = 1'b0; m_under = 1'b0;
    end else begin
      acc  = in_valid && m_ready_en && !m_hold_full;
      m_ws = 1'b0;
      if (enable) begin
        if (!display_area_enable) begin
          m_q.delete();
          m_out = 1'b0; m_valid = 1'b0;
        end else begin
          if (m_q.size() == 0) begin
            if (m_hold_full) begin
              for (int i = 0; i < WIDTH; i++)
                for (int r = 0; r <= int'(m_hold.sc); r++)
                  m_q.push_back(m_hold.lsb ? m_hold.w[i] : m_hold.w[WIDTH-1-i]);
              m_hold_full = 1'b0;
              m_ws = 1'b1;
            end else begin
              m_out = 1'b0; m_valid = 1'b0; m_under = 1'b1;
            end
          end
          if (m_q.size() > 0) begin
            m_out   = m_q.pop_front();
            m_valid = 1'b1;
          end
        end
      end
      if (acc) begin
        m_hold      = '{w: parallel_in, lsb: lsb_first, sc: scale};
        m_hold_full = 1'b1;
      end
      m_ready_en = 1'b1;
    end
  endtask

  // One clk: drive inputs, advance the model, then sample 1 time unit after the edge
  task automatic step(input logic en);
    logic acc;
    enable   = en;
    in_valid = feed_gate && (tx_q.size() > 0);
    if (tx_q.size() > 0) begin
      parallel_in = tx_q[0].w;
      lsb_first   = tx_q[0].lsb;
      scale       = tx_q[0].sc;
    end
    model_update();
    acc = in_valid && in_ready && !reset;
    @(posedge clk);
    #1;
    if (acc) void'(tx_q.pop_front());
  endtask

  task automatic do_reset();
    tx_q.delete();
    feed_gate = 1'b1;
    display_area_enable = 1'b0;
    reset = 1'b1;
    step(1'b0);
    reset = 1'b0;
    step(1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tx_q.delete();
    step(1'b1);
    step(1'b1);
    n_tests++;
    if ({serial_out, serial_valid, word_start, underrun, in_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got=%b exp=00000",
               {serial_out, serial_valid, word_start, underrun, in_ready});
    end
    reset = 1'b0;
    step(1'b0);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready got=%b exp=1", in_ready);
    end
  endtask

  // Single word at one tick per clk in the requested bit order
  task automatic test_order(input logic lsb);
    logic [WIDTH-1:0] w;
    logic [2:0]       exp;
    w = 8'hC1;
    do_reset();
    display_area_enable = 1'b1;
    tx_q.push_back('{w: w, lsb: lsb, sc: 2'd0});
    step(1'b0);
    for (int t = 0; t < WIDTH; t++) begin
      step(1'b1);
      exp = {(lsb ? w[t] : w[WIDTH-1-t]), 1'b1, (t == 0)};
      n_tests++;
      if ({serial_out, serial_valid, word_start} !== exp) begin
        n_fail++;
        $display("FAIL order_lsb%0d_tick%0d got=%b exp=%b", lsb, t,
                 {serial_out, serial_valid, word_start}, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pat;
    logic [2:0]  exp;
    pat = 16'hC13E;
    do_reset();
    display_area_enable = 1'b1;
    tx_q.push_back('{w: 8'hC1, lsb: 1'b0, sc: 2'd0});
    tx_q.push_back('{w: 8'h3E, lsb: 1'b0, sc: 2'd0});
    step(1'b0);
    for (int t = 0; t < 16; t++) begin
      step(1'b1);
      exp = {pat[15-t], 1'b1, (t == 0 || t == 8)};
      n_tests++;
      if ({serial_out, serial_valid, word_start} !== exp) begin
        n_fail++;
        $display("FAIL b2b_tick%0d got=%b exp=%b", t,
                 {serial_out, serial_valid, word_start}, exp);
      end
      if (t == 0) begin
        n_tests++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready_after_load got=%b exp=1", in_ready);
        end
      end
      if (t != 15) repeat (3) step(1'b0);
    end
    n_tests++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_underrun got=%b exp=0", underrun);
    end
  endtask

  task automatic test_scale();
    logic [2:0] exp;
    do_reset();
    display_area_enable = 1'b1;
    tx_q.push_back('{w: 8'h80, lsb: 1'b0, sc: 2'd2});
    tx_q.push_back('{w: 8'hAA, lsb: 1'b0, sc: 2'd0});
    step(1'b0);
    for (int t = 0; t < 25; t++) begin
      step(1'b1);
      exp = {(t < 3 || t == 24), 1'b1, (t == 0 || t == 24)};
      n_tests++;
      if ({serial_out, serial_valid, word_start} !== exp) begin
        n_fail++;
        $display("FAIL scale_tick%0d got=%b exp=%b", t,
                 {serial_out, serial_valid, word_start}, exp);
      end
    end
  endtask

  task automatic test_blanking();
    logic [WIDTH-1:0] w1, w2;
    logic [2:0]       exp;
    w1 = 8'hC1;
    w2 = 8'h3E;
    do_reset();
    display_area_enable = 1'b1;
    tx_q.push_back('{w: w1, lsb: 1'b0, sc: 2'd0});
    tx_q.push_back('{w: w2, lsb: 1'b0, sc: 2'd0});
    step(1'b0);
    for (int t = 0; t < 3; t++) begin
      step(1'b1);
      exp = {w1[WIDTH-1-t], 1'b1, (t == 0)};
      n_tests++;
      if ({serial_out, serial_valid, word_start} !== exp) begin
        n_fail++;
        $display("FAIL blank_pre_tick%0d got=%b exp=%b", t,
                 {serial_out, serial_valid, word_start}, exp);
      end
    end
    display_area_enable = 1'b0;
    step(1'b1);
    n_tests++;
    if ({serial_out, serial_valid, word_start} !== 3'b000) begin
      n_fail++;
      $display("FAIL blank_tick got=%b exp=000", {serial_out, serial_valid, word_start});
    end
    display_area_enable = 1'b1;
    for (int t = 0; t < WIDTH; t++) begin
      step(1'b1);
      exp = {w2[WIDTH-1-t], 1'b1, (t == 0)};
      n_tests++;
      if ({serial_out, serial_valid, word_start} !== exp) begin
        n_fail++;
        $display("FAIL blank_post_tick%0d got=%b exp=%b", t,
                 {serial_out, serial_valid, word_start}, exp);
      end
    end
    n_tests++;
    if (underrun !== 1'b0) begin
      n_fail++;
      $display("FAIL blank_underrun got=%b exp=0", underrun);
    end
  endtask

  task automatic test_underrun_reset();
    do_reset();
    display_area_enable = 1'b1;
    tx_q.push_back('{w: 8'hA5, lsb: 1'b0, sc: 2'd0});
    step(1'b0);
    repeat (WIDTH) step(1'b1);
    step(1'b1);
    n_tests++;
    if ({serial_out, serial_valid, word_start, underrun} !== 4'b0001) begin
      n_fail++;
      $display("FAIL underrun_tick got=%b exp=0001",
               {serial_out, serial_valid, word_start, underrun});
    end
    display_area_enable = 1'b0;
    step(1'b1);
    step(1'b1);
    n_tests++;
    if (underrun !== 1'b1) begin
      n_fail++;
      $display("FAIL underrun_sticky got=%b exp=1", underrun);
    end
    tx_q.push_back('{w: 8'hFF, lsb: 1'b0, sc: 2'd0});
    step(1'b0);
    display_area_enable = 1'b1;
    repeat (3) step(1'b1);
    reset = 1'b1;
    step(1'b1);
    n_tests++;
    if ({serial_out, serial_valid, word_start, underrun, in_ready} !== 5'b0) begin
      n_fail++;
      $display("FAIL midword_reset got=%b exp=00000",
               {serial_out, serial_valid, word_start, underrun, in_ready});
    end
    reset = 1'b0;
    display_area_enable = 1'b0;
    step(1'b0);
    n_tests++;
    if ({in_ready, underrun} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_release got=%b exp=10", {in_ready, underrun});
    end
  endtask

  task automatic test_random();
    logic [4:0] exp, got;
    do_reset();
    display_area_enable = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      if (tx_q.size() < 2 && $urandom_range(0, 3) != 0)
        tx_q.push_back('{w: WIDTH'($urandom), lsb: 1'($urandom), sc: SCALE_W'($urandom)});
      feed_gate = ($urandom_range(0, 5) != 0);
      if (display_area_enable) begin
        if ($urandom_range(0, 59) == 0) display_area_enable = 1'b0;
      end else if ($urandom_range(0, 7) == 0) begin
        display_area_enable = 1'b1;
      end
      reset = ($urandom_range(0, 799) == 0);
      step($urandom_range(0, 2) != 0);
      exp = {m_ready_en && !m_hold_full, m_out, m_valid, m_ws, m_under};
      got = {in_ready, serial_out, serial_valid, word_start, underrun};
      n_tests++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random_cycle%0d rdy/out/vld/ws/und got=%b exp=%b", c, got, exp);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_order(1'b0);
    test_order(1'b1);
    test_back_to_back();
    test_scale();
    test_blanking();
    test_underrun_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
